// File: rtl/time_of_day_bcd.sv
// Settable 24-hour BCD time-of-day counter with HH/MM set mode and blink.
// Latency: time digits update on the counting edge; button presses act on the 3rd sampled-high edge.
// Backpressure: none; Enable ticks and button presses are consumed as they arrive.
module time_of_day_bcd #(
  parameter logic [7:0] RESET_HOUR = 8'h00,
  parameter logic [7:0] RESET_MIN  = 8'h00
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       Enable,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [3:0] Q0,
  output logic [3:0] Q1,
  output logic [3:0] Q2,
  output logic [3:0] Q3,
  output logic [3:0] Q4,
  output logic [3:0] Q5,
  output logic [5:0] blank,
  output logic [1:0] mode,
  output logic       Midnight
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic       mode_s1, mode_s2, mode_prev;
  logic       inc_s1, inc_s2, inc_prev;
  logic       mode_evt;
  logic       inc_evt;

  // Packed BCD fields: [7:4] tens, [3:0] ones.
  logic [7:0] sec, min, hr;
  logic [7:0] sec_nxt, min_nxt, hr_nxt;
  logic       day_wrap;

  logic       blink, blink_nxt;
  logic [5:0] blank_nxt;

  // Minutes/seconds increment: 00..59, wraps to 00.
  function automatic logic [7:0] inc_sexa(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] >= 4'd9) begin
      r[3:0] = 4'd0;
      if (v[7:4] >= 4'd5) r[7:4] = 4'd0;
      else                r[7:4] = v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  // Hours increment: 00..23, wraps to 00.
  function automatic logic [7:0] inc_hour(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v >= 8'h23) begin
      r = 8'h00;
    end else if (v[3:0] >= 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  // Two-flop synchronizers plus previous-value flops for rising-edge detection.
  always_ff @(posedge mclk) begin
    if (reset) begin
      mode_s1   <= 1'b0;
      mode_s2   <= 1'b0;
      mode_prev <= 1'b0;
      inc_s1    <= 1'b0;
      inc_s2    <= 1'b0;
      inc_prev  <= 1'b0;
    end else begin
      mode_s1   <= mode_btn;
      mode_s2   <= mode_s1;
      mode_prev <= mode_s2;
      inc_s1    <= inc_btn;
      inc_s2    <= inc_s1;
      inc_prev  <= inc_s2;
    end
  end

  // A coincident mode press swallows the increment press.
  assign mode_evt = mode_s2 & ~mode_prev;
  assign inc_evt  = inc_s2 & ~inc_prev & ~mode_evt;

  // FSM state register.
  always_ff @(posedge mclk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // FSM next state: each mode press steps RUN -> SET_HH -> SET_MM -> RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (mode_evt) state_nxt = SET_HH;
      SET_HH:  if (mode_evt) state_nxt = SET_MM;
      SET_MM:  if (mode_evt) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // FSM outputs.
  always_comb begin
    mode = state;
  end

  // Next time value: ticking in RUN, manual field increments in the set states.
  always_comb begin
    sec_nxt  = sec;
    min_nxt  = min;
    hr_nxt   = hr;
    day_wrap = 1'b0;
    case (state)
      RUN: begin
        if (Enable) begin
          sec_nxt = inc_sexa(sec);
          if (sec == 8'h59) begin
            min_nxt = inc_sexa(min);
            if (min == 8'h59) begin
              hr_nxt   = inc_hour(hr);
              day_wrap = (hr == 8'h23);
            end
          end
        end
      end
      SET_HH: begin
        if (inc_evt) hr_nxt = inc_hour(hr);
      end
      SET_MM: begin
        if (inc_evt)  min_nxt = inc_sexa(min);
        // Leaving set mode restarts the minute from zero seconds.
        if (mode_evt) sec_nxt = 8'h00;
      end
      default: ;
    endcase
  end

  // Blink flag and the blanking mask it drives, both aligned with the next state.
  always_comb begin
    blink_nxt = blink;
    if (state_nxt != state)              blink_nxt = 1'b0;
    else if (state != RUN && Enable)     blink_nxt = ~blink;
    blank_nxt = 6'b000000;
    case (state_nxt)
      SET_HH:  if (blink_nxt) blank_nxt = 6'b110000;
      SET_MM:  if (blink_nxt) blank_nxt = 6'b001100;
      default: blank_nxt = 6'b000000;
    endcase
  end

  // Time, blink, blank and midnight registers.
  always_ff @(posedge mclk) begin
    if (reset) begin
      sec      <= 8'h00;
      min      <= RESET_MIN;
      hr       <= RESET_HOUR;
      blink    <= 1'b0;
      blank    <= 6'b000000;
      Midnight <= 1'b0;
    end else begin
      sec      <= sec_nxt;
      min      <= min_nxt;
      hr       <= hr_nxt;
      blink    <= blink_nxt;
      blank    <= blank_nxt;
      Midnight <= day_wrap;
    end
  end

  assign Q0 = sec[3:0];
  assign Q1 = sec[7:4];
  assign Q2 = min[3:0];
  assign Q3 = min[7:4];
  assign Q4 = hr[3:0];
  assign Q5 = hr[7:4];

endmodule

// File: tb/tb_time_of_day_bcd.sv
// Directed bench for time_of_day_bcd: run/set modes, wraps, blink and reset override.
module tb_time_of_day_bcd;

  logic       mclk;
  logic       reset;
  logic       Enable;
  logic       mode_btn;
  logic       inc_btn;
  logic [3:0] Q0, Q1, Q2, Q3, Q4, Q5;
  logic [5:0] blank;
  logic [1:0] mode;
  logic       Midnight;

  int checks;
  int errors;
  int mid_cnt;

  time_of_day_bcd dut (
    .mclk     (mclk),
    .reset    (reset),
    .Enable   (Enable),
    .mode_btn (mode_btn),
    .inc_btn  (inc_btn),
    .Q0       (Q0),
    .Q1       (Q1),
    .Q2       (Q2),
    .Q3       (Q3),
    .Q4       (Q4),
    .Q5       (Q5),
    .blank    (blank),
    .mode     (mode),
    .Midnight (Midnight)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_time(input string tag, input logic [23:0] exp);
    check(tag, {8'h00, Q5, Q4, Q3, Q2, Q1, Q0}, {8'h00, exp});
  endtask

  // One-cycle Enable tick; Midnight is sampled in the cycle after the tick edge.
  task automatic pulse_enable();
    @(negedge mclk);
    Enable = 1'b1;
    @(negedge mclk);
    Enable = 1'b0;
    if (Midnight) mid_cnt++;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) pulse_enable();
  endtask

  // Hold a button for three sampling edges (event lands on the third), then release.
  task automatic press(input logic m, input logic i);
    @(negedge mclk);
    mode_btn = m;
    inc_btn  = i;
    repeat (3) @(negedge mclk);
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    repeat (2) @(negedge mclk);
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) press(1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge mclk);
    reset = 1'b1;
    repeat (2) @(negedge mclk);
    reset = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    mid_cnt  = 0;
    reset    = 1'b1;
    Enable   = 1'b0;
    mode_btn = 1'b0;
    inc_btn  = 1'b0;

    // Reset state with default parameters.
    repeat (2) @(negedge mclk);
    check_time("reset_time", 24'h000000);
    check("reset_mode", 32'(mode), 32'd0);
    check("reset_blank", 32'(blank), 32'd0);
    check("reset_midnight", 32'(Midnight), 32'd0);
    reset = 1'b0;

    // One minute of ticks.
    mid_cnt = 0;
    pulses(60);
    check_time("run_60_ticks", 24'h000100);
    check("run_60_no_midnight", 32'(mid_cnt), 32'd0);

    // Set 23:59 and run into the day wrap.
    do_reset();
    press(1'b1, 1'b0);
    check("enter_set_hh", 32'(mode), 32'd1);
    incs(23);
    check_time("set_hh_23", 24'h230000);
    press(1'b1, 1'b0);
    check("enter_set_mm", 32'(mode), 32'd2);
    incs(59);
    check_time("set_mm_59", 24'h235900);
    press(1'b1, 1'b0);
    check("back_to_run", 32'(mode), 32'd0);
    mid_cnt = 0;
    pulses(59);
    check_time("at_235959", 24'h235959);
    check("no_early_midnight", 32'(mid_cnt), 32'd0);
    @(negedge mclk);
    Enable = 1'b1;
    @(negedge mclk);
    Enable = 1'b0;
    check_time("day_wrap_time", 24'h000000);
    check("midnight_high", 32'(Midnight), 32'd1);
    @(negedge mclk);
    check("midnight_one_cycle", 32'(Midnight), 32'd0);

    // Modulo wraps in set mode, seconds held then cleared on return to RUN.
    do_reset();
    mid_cnt = 0;
    pulses(5);
    check_time("pre_set_secs", 24'h000005);
    press(1'b1, 1'b0);
    incs(25);
    check_time("hour_wrap_25", 24'h010005);
    press(1'b1, 1'b0);
    incs(61);
    check_time("min_wrap_61", 24'h010105);
    press(1'b1, 1'b0);
    check("run_after_set", 32'(mode), 32'd0);
    check_time("secs_cleared", 24'h010100);
    check("no_midnight_on_set_wrap", 32'(mid_cnt), 32'd0);

    // Blink in SET_HH at 12:34:56 and coincident mode+inc presses.
    do_reset();
    press(1'b1, 1'b0);
    incs(12);
    press(1'b1, 1'b0);
    incs(34);
    press(1'b1, 1'b0);
    pulses(56);
    check_time("at_123456", 24'h123456);
    press(1'b1, 1'b0);
    check("set_hh_mode", 32'(mode), 32'd1);
    check("set_hh_blank0", 32'(blank), 32'b000000);
    pulse_enable();
    check("blink_1", 32'(blank), 32'b110000);
    pulse_enable();
    check("blink_2", 32'(blank), 32'b000000);
    pulse_enable();
    check("blink_3", 32'(blank), 32'b110000);
    check_time("held_in_set_hh", 24'h123456);
    press(1'b1, 1'b1);
    check("coincident_mode", 32'(mode), 32'd2);
    check_time("coincident_no_inc", 24'h123456);
    check("blink_cleared", 32'(blank), 32'b000000);
    pulse_enable();
    check("blink_set_mm", 32'(blank), 32'b001100);

    // Reset overrides SET_MM at 05:17 even with Enable and a button active.
    do_reset();
    press(1'b1, 1'b0);
    incs(5);
    press(1'b1, 1'b0);
    incs(17);
    pulse_enable();
    check_time("at_0517", 24'h051700);
    check("pre_reset_blank", 32'(blank), 32'b001100);
    @(negedge mclk);
    reset   = 1'b1;
    Enable  = 1'b1;
    inc_btn = 1'b1;
    @(negedge mclk);
    reset   = 1'b0;
    Enable  = 1'b0;
    inc_btn = 1'b0;
    check("reset_mid_set_mode", 32'(mode), 32'd0);
    check_time("reset_mid_set_time", 24'h000000);
    check("reset_mid_set_blank", 32'(blank), 32'd0);
    repeat (4) @(negedge mclk);
    check_time("no_stray_event", 24'h000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
